// File: rtl/approx_err_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : approx_err_checker                                         |
// | Description : Exhaustive sweep checker for an exact/approximate circuit  |
// |               pair. Drives every input vector, compares the two output   |
// |               words as unsigned integers and reports the worst-case      |
// |               absolute error, the number of erroneous vectors, the first |
// |               vector whose error exceeds ET, and pass/fail against ET.   |
// | Ports       : clk, rst_n (async, active low), start (1-cycle request)    |
// |               vec        -> vector driven to both circuits (bit0 = in0)  |
// |               exact_out / approx_out <- circuit outputs for current vec  |
// |               busy, done, pass, max_err, err_count, first_fail_vec       |
// |               err_sum    (only with APPROX_ERR_CHECKER_ERR_SUM_EN)       |
// | Options     : `define APPROX_ERR_CHECKER_ERR_SUM_EN adds the err_sum     |
// |               accumulator/output (sum of |exact-approx| over all vecs).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module approx_err_checker #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3,
   parameter int ET    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [N_IN-1:0]    vec,
   input  logic [N_OUT-1:0]   exact_out,
   input  logic [N_OUT-1:0]   approx_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N_OUT-1:0]   max_err,
   output logic [N_IN:0]      err_count,
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
   output logic [N_OUT+N_IN-1:0] err_sum,
`endif
   output logic [N_IN-1:0]    first_fail_vec
);

   localparam logic [N_IN-1:0] c_vec_last = '1;
   localparam logic [N_IN-1:0] c_vec_one  = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN:0]   c_cnt_one  = {{N_IN{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_last_sampled;   // final vector already captured in stage 1
   logic              r_p_valid;
   logic [N_OUT-1:0]  r_p_exact;
   logic [N_OUT-1:0]  r_p_approx;
   logic [N_IN-1:0]   r_p_vec;

   logic [N_OUT-1:0]  w_diff;
   logic              w_over_et;

   // Unsigned absolute difference, always fits in N_OUT bits.
   assign w_diff    = (r_p_exact >= r_p_approx) ? (r_p_exact - r_p_approx)
                                                : (r_p_approx - r_p_exact);
   // Widened compare so an ET at or above the output range simply never trips.
   assign w_over_et = (int'(w_diff) > ET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_last_sampled <= 1'b0;
         r_p_valid      <= 1'b0;
         r_p_exact      <= '0;
         r_p_approx     <= '0;
         r_p_vec        <= '0;
         vec            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b1;
         max_err        <= '0;
         err_count      <= '0;
         first_fail_vec <= '0;
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
         err_sum        <= '0;
`endif
      end else begin
         // Stage 2: fold one registered comparison into the statistics.
         if (r_p_valid) begin
            if (w_diff > max_err)
               max_err <= w_diff;
            if (w_diff != '0)
               err_count <= err_count + c_cnt_one;
            if (w_over_et && pass) begin
               first_fail_vec <= r_p_vec;
               pass           <= 1'b0;
            end
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
            err_sum <= err_sum + {{N_IN{1'b0}}, w_diff};
`endif
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               r_p_valid <= 1'b0;
               if (start) begin
                  r_state        <= S_SWEEP;
                  r_last_sampled <= 1'b0;
                  vec            <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b1;
                  max_err        <= '0;
                  err_count      <= '0;
                  first_fail_vec <= '0;
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
                  err_sum        <= '0;
`endif
               end
            end
            S_SWEEP: begin
               if (!r_last_sampled) begin
                  // Stage 1: capture the pair for the vector currently driven.
                  r_p_valid  <= 1'b1;
                  r_p_exact  <= exact_out;
                  r_p_approx <= approx_out;
                  r_p_vec    <= vec;
                  if (vec == c_vec_last)
                     r_last_sampled <= 1'b1;   // vec holds, no wrap
                  else
                     vec <= vec + c_vec_one;
               end else begin
                  // Last sample is in stage 2 this cycle; stop feeding.
                  r_p_valid <= 1'b0;
                  r_state   <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_p_valid <= 1'b0;
               r_state   <= S_DONE;
               busy      <= 1'b0;
               done      <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_p_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_approx_err_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_approx_err_checker                                      |
// | Description : Self-checking bench for approx_err_checker. Circuit pairs  |
// |               are lookup tables indexed by vec; expected statistics are  |
// |               computed from the tables with plain arithmetic.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_approx_err_checker;

   localparam int N_IN  = 4;
   localparam int N_OUT = 3;
   localparam int ET    = 3;
   localparam int NV    = 1 << N_IN;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [N_IN-1:0]   vec;
   logic [N_OUT-1:0]  exact_out;
   logic [N_OUT-1:0]  approx_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_OUT-1:0]  max_err;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   first_fail_vec;
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
   logic [N_OUT+N_IN-1:0] err_sum;
`endif

   int checks   = 0;
   int failures = 0;

   // Circuit-pair models
   int tbl_e [NV];
   int tbl_a [NV];

   // Expected results
   int exp_max, exp_cnt, exp_sum, exp_ffv, exp_pass;

   always #5 clk = ~clk;

   always_comb begin
      exact_out  = N_OUT'(tbl_e[vec]);
      approx_out = N_OUT'(tbl_a[vec]);
   end

   approx_err_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .vec            (vec),
      .exact_out      (exact_out),
      .approx_out     (approx_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .max_err        (max_err),
      .err_count      (err_count),
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
      .err_sum        (err_sum),
`endif
      .first_fail_vec (first_fail_vec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // mode 0: approx tied to exact, 1: approx=0, 2: approx=exact^1, 3: random pair
   task automatic load_pair(input int mode);
      for (int v = 0; v < NV; v++) begin
         tbl_e[v] = v % 8;
         case (mode)
            0: tbl_a[v] = tbl_e[v];
            1: tbl_a[v] = 0;
            2: tbl_a[v] = tbl_e[v] ^ 1;
            default: begin
               tbl_e[v] = $urandom_range(0, 7);
               tbl_a[v] = $urandom_range(0, 7);
            end
         endcase
      end
   endtask

   task automatic model();
      int d;
      exp_max = 0; exp_cnt = 0; exp_sum = 0; exp_ffv = 0; exp_pass = 1;
      for (int v = 0; v < NV; v++) begin
         d = tbl_e[v] - tbl_a[v];
         if (d < 0) d = -d;
         if (d > exp_max) exp_max = d;
         if (d != 0) exp_cnt++;
         exp_sum += d;
         if (d > ET && exp_pass == 1) begin
            exp_pass = 0;
            exp_ffv  = v;
         end
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, ".max_err"},   32'(max_err),        exp_max);
      check({tag, ".err_count"}, 32'(err_count),      exp_cnt);
      check({tag, ".pass"},      32'(pass),           exp_pass);
      check({tag, ".ffv"},       32'(first_fail_vec), exp_ffv);
`ifdef APPROX_ERR_CHECKER_ERR_SUM_EN
      check({tag, ".err_sum"},   32'(err_sum),        exp_sum);
`endif
   endtask

   // Called #1 after a rising edge. extra_at>0 re-pulses start so that the
   // edge numbered extra_at sees it while the sweep is busy.
   task automatic run_sweep(input string tag, input int extra_at);
      int n;
      model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, ".busy0"}, 32'(busy), 1);
      check({tag, ".done0"}, 32'(done), 0);
      n = 0;
      while (!done && n < 40) begin
         start = (n == extra_at - 1) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check({tag, ".latency"}, n, 18);
      check({tag, ".busy_end"}, 32'(busy), 0);
      check_results(tag);
      // Results hold stable in DONE.
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".hold_done"}, 32'(done), 1);
      check({tag, ".hold_max"},  32'(max_err), exp_max);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      load_pair(0);
      repeat (2) @(posedge clk);
      #1;
      check("rst.vec",   32'(vec), 0);
      check("rst.busy",  32'(busy), 0);
      check("rst.done",  32'(done), 0);
      check("rst.pass",  32'(pass), 1);
      check("rst.max",   32'(max_err), 0);
      check("rst.cnt",   32'(err_count), 0);
      check("rst.ffv",   32'(first_fail_vec), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      load_pair(0); run_sweep("tied", 0);
      load_pair(1); run_sweep("zero", 0);
      load_pair(2); run_sweep("xor1", 0);
      // Back-to-back from DONE with a failing pair, then a passing one.
      load_pair(1); run_sweep("b2b_fail", 0);
      load_pair(2); run_sweep("b2b_pass", 0);
      // Extra start mid-sweep must be ignored.
      load_pair(1); run_sweep("extra_start", 5);

      // Asynchronous reset in the middle of a failing sweep.
      load_pair(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.vec",  32'(vec), 0);
      check("midrst.busy", 32'(busy), 0);
      check("midrst.done", 32'(done), 0);
      check("midrst.pass", 32'(pass), 1);
      check("midrst.max",  32'(max_err), 0);
      check("midrst.cnt",  32'(err_count), 0);
      check("midrst.ffv",  32'(first_fail_vec), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_sweep("after_rst", 0);

      // Randomized circuit pairs.
      for (int k = 0; k < 6; k++) begin
         load_pair(3);
         run_sweep($sformatf("rand%0d", k), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
